avg_window_ctrl: RTL and testbench

Sequencer for the 3x3 averaging datapath. It accepts a raster pixel stream, holds the two previous lines in line buffers, and drives the nine 24-bit window taps (upper/middle/under line × three columns). It issues a window-valid strobe plus a valid/coordinate tag aligned to the averager's one-cycle output latency. It sits between the video input and the average filter, and feeds the filtered-pixel writer.

---
 rtl/avg_window_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_avg_window_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/avg_window_ctrl.sv
// avg_window_ctrl: window sequencer in front of the 3x3 averager.
// Takes a raster pixel stream, keeps the two previous lines in line buffers and
// presents a 3x3 window of 24-bit taps, plus a valid/coordinate tag that lines
// up with the averager's one-cycle output latency.
//
// Ports:
//   CLK, RESET                 clock, synchronous active-high reset
//   DIN[23:0]                  pixel {R,G,B}
//   DIN_VALID/DIN_SOF/DIN_SOL  pixel qualifier, start of frame, start of line
//   Dyx OUT (y=0 upper..2 under, x=0 newest column..2 oldest)  window taps
//   WIN_VALID                  taps hold a complete window
//   AVG_VALID, AVG_X, AVG_Y    averager output valid and its centre coordinate
//   ERR                        sticky line-length error
//
// Optional feature: define AVG_CTRL_ERR_EN to enable line-length checking.
// Without it ERR is tied 0, excess pixels are ignored and short lines are not flagged.
module avg_window_ctrl #(
  parameter int unsigned WIDTH = 640,
  parameter int unsigned CW    = 10,
  parameter int unsigned RW    = 10
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [23:0]   DIN,
  input  logic          DIN_VALID,
  input  logic          DIN_SOF,
  input  logic          DIN_SOL,
  output logic [23:0]   D02OUT,
  output logic [23:0]   D01OUT,
  output logic [23:0]   D00OUT,
  output logic [23:0]   D12OUT,
  output logic [23:0]   D11OUT,
  output logic [23:0]   D10OUT,
  output logic [23:0]   D22OUT,
  output logic [23:0]   D21OUT,
  output logic [23:0]   D20OUT,
  output logic          WIN_VALID,
  output logic          AVG_VALID,
  output logic [CW-1:0] AVG_X,
  output logic [RW-1:0] AVG_Y,
  output logic          ERR
);

  localparam int unsigned AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  // Column counter carries one extra bit so it can hold WIDTH even when 2^CW == WIDTH.
  localparam logic [CW:0] WidthC = (CW + 1)'(WIDTH);

  typedef enum logic [1:0] {StIdle, StPrime, StRun, StErrHold} state_e;

  state_e        state_q;
  logic [CW:0]   col_q;   // column of the next non-SOL pixel
  logic [RW-1:0] row_q;

  logic [23:0] d00_q, d01_q, d02_q;
  logic [23:0] d10_q, d11_q, d12_q;
  logic [23:0] d20_q, d21_q, d22_q;
  logic          win_q;
  logic [CW-1:0] win_x_q;
  logic [RW-1:0] win_y_q;
  logic          avg_valid_q;
  logic [CW-1:0] avg_x_q;
  logic [RW-1:0] avg_y_q;

  logic [23:0] lb0 [WIDTH];  // row y-1
  logic [23:0] lb1 [WIDTH];  // row y-2

  logic          acc;
  logic          new_line;
  logic [CW:0]   pix_x;
  logic [RW-1:0] row_inc;
  logic [RW-1:0] pix_y;
  logic          in_range;
  logic [AW-1:0] idx;
  logic [23:0]   lb0_rd;
  logic [23:0]   lb1_rd;
  logic          err_event;

  always_comb begin
    acc      = DIN_VALID && ((state_q != StIdle) || DIN_SOF);
    new_line = DIN_SOL && !DIN_SOF;
    pix_x    = (DIN_SOF || DIN_SOL) ? '0 : col_q;
    row_inc  = (row_q == '1) ? row_q : row_q + 1'b1;
    pix_y    = DIN_SOF ? '0 : (DIN_SOL ? row_inc : row_q);
    in_range = (pix_x < WidthC);
    idx      = pix_x[AW-1:0];
    lb0_rd   = lb0[idx];
    lb1_rd   = lb1[idx];
  end

`ifdef AVG_CTRL_ERR_EN
  // Line must be exactly WIDTH pixels: short at SOL, or overlong pixel mid-line.
  assign err_event = acc && !DIN_SOF && ((state_q == StPrime) || (state_q == StRun)) &&
                     (DIN_SOL ? (col_q != WidthC) : (col_q == WidthC));
`else
  assign err_event = 1'b0;
`endif

  // Line buffers: not reset, read-before-write on the same column.
  always_ff @(posedge CLK) begin
    if (!RESET && acc && in_range) begin
      lb1[idx] <= lb0_rd;
      lb0[idx] <= DIN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= StIdle;
      col_q       <= '0;
      row_q       <= '0;
      d00_q       <= '0;
      d01_q       <= '0;
      d02_q       <= '0;
      d10_q       <= '0;
      d11_q       <= '0;
      d12_q       <= '0;
      d20_q       <= '0;
      d21_q       <= '0;
      d22_q       <= '0;
      win_q       <= 1'b0;
      win_x_q     <= '0;
      win_y_q     <= '0;
      avg_valid_q <= 1'b0;
      avg_x_q     <= '0;
      avg_y_q     <= '0;
    end else begin
      win_q       <= 1'b0;
      avg_valid_q <= win_q;
      avg_x_q     <= win_x_q;
      avg_y_q     <= win_y_q;
      if (acc) begin
        row_q <= pix_y;
        // Saturates at WIDTH so overlong lines cannot wrap back into range.
        col_q <= in_range ? pix_x + 1'b1 : pix_x;
        if (DIN_SOF) begin
          state_q <= StPrime;
        end else if (err_event) begin
          state_q <= StErrHold;
        end else if (state_q == StPrime && new_line && row_inc == RW'(2)) begin
          state_q <= StRun;
        end
        if (in_range) begin
          d02_q <= d01_q;
          d01_q <= d00_q;
          d00_q <= lb1_rd;
          d12_q <= d11_q;
          d11_q <= d10_q;
          d10_q <= lb0_rd;
          d22_q <= d21_q;
          d21_q <= d20_q;
          d20_q <= DIN;
          win_q   <= (state_q == StRun) && !err_event && (pix_x >= (CW + 1)'(2));
          win_x_q <= CW'(pix_x - 1'b1);
          win_y_q <= pix_y - 1'b1;
        end
      end
    end
  end

`ifdef AVG_CTRL_ERR_EN
  logic err_q;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      err_q <= 1'b0;
    end else if (err_event) begin
      err_q <= 1'b1;
    end
  end
  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

  assign D02OUT    = d02_q;
  assign D01OUT    = d01_q;
  assign D00OUT    = d00_q;
  assign D12OUT    = d12_q;
  assign D11OUT    = d11_q;
  assign D10OUT    = d10_q;
  assign D22OUT    = d22_q;
  assign D21OUT    = d21_q;
  assign D20OUT    = d20_q;
  assign WIN_VALID = win_q;
  assign AVG_VALID = avg_valid_q;
  assign AVG_X     = avg_x_q;
  assign AVG_Y     = avg_y_q;

endmodule

// File: tb/tb_avg_window_ctrl.sv
// Directed bench for avg_window_ctrl with WIDTH=4 and 4x4 frames whose pixel
// (y,x) is 0x010101*(4y+x). A small averager stand-in registers the channel means
// of the taps so the AVG tag can be checked against the expected filtered pixel.
module tb_avg_window_ctrl;
  localparam int unsigned W  = 4;
  localparam int unsigned CW = 3;
  localparam int unsigned RW = 4;

  logic          CLK;
  logic          RESET;
  logic [23:0]   DIN;
  logic          DIN_VALID;
  logic          DIN_SOF;
  logic          DIN_SOL;
  logic [23:0]   D02OUT, D01OUT, D00OUT;
  logic [23:0]   D12OUT, D11OUT, D10OUT;
  logic [23:0]   D22OUT, D21OUT, D20OUT;
  logic          WIN_VALID;
  logic          AVG_VALID;
  logic [CW-1:0] AVG_X;
  logic [RW-1:0] AVG_Y;
  logic          ERR;

  avg_window_ctrl #(.WIDTH(W), .CW(CW), .RW(RW)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .DIN       (DIN),
    .DIN_VALID (DIN_VALID),
    .DIN_SOF   (DIN_SOF),
    .DIN_SOL   (DIN_SOL),
    .D02OUT    (D02OUT),
    .D01OUT    (D01OUT),
    .D00OUT    (D00OUT),
    .D12OUT    (D12OUT),
    .D11OUT    (D11OUT),
    .D10OUT    (D10OUT),
    .D22OUT    (D22OUT),
    .D21OUT    (D21OUT),
    .D20OUT    (D20OUT),
    .WIN_VALID (WIN_VALID),
    .AVG_VALID (AVG_VALID),
    .AVG_X     (AVG_X),
    .AVG_Y     (AVG_Y),
    .ERR       (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [7:0] ch_avg(input logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7, a8);
    int s;
    s = int'(a0) + int'(a1) + int'(a2) + int'(a3) + int'(a4) + int'(a5) + int'(a6) +
        int'(a7) + int'(a8);
    return 8'(s / 9);
  endfunction

  // Averager stand-in: one register stage behind the taps.
  logic [23:0] dout;
  always_ff @(posedge CLK) begin
    for (int c = 0; c < 3; c++) begin
      dout[c*8 +: 8] <= ch_avg(D00OUT[c*8 +: 8], D01OUT[c*8 +: 8], D02OUT[c*8 +: 8],
                               D10OUT[c*8 +: 8], D11OUT[c*8 +: 8], D12OUT[c*8 +: 8],
                               D20OUT[c*8 +: 8], D21OUT[c*8 +: 8], D22OUT[c*8 +: 8]);
    end
  end

  int   checks = 0;
  int   errors = 0;
  int   avg_pulses = 0;
  logic last_win = 1'b0;
  int   last_x = 0;
  int   last_y = 0;
  logic err_exp = 1'b0;

  function automatic logic [23:0] pix(input int y, input int x);
    return 24'((4 * y + x) * 32'h010101);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, sample at the next falling edge.
  task automatic step(input logic v, input logic sof, input logic sol, input int y,
                      input int x, input logic exp_win);
    DIN_VALID = v;
    DIN_SOF   = sof;
    DIN_SOL   = sol;
    DIN       = v ? pix(y, x) : 24'hA5A5A5;
    @(negedge CLK);
    chk("win_valid", {31'd0, WIN_VALID}, {31'd0, exp_win});
    chk("avg_valid", {31'd0, AVG_VALID}, {31'd0, last_win});
    chk("err", {31'd0, ERR}, {31'd0, err_exp});
    if (last_win) begin
      avg_pulses++;
      chk("avg_x", 32'(AVG_X), 32'(last_x - 1));
      chk("avg_y", 32'(AVG_Y), 32'(last_y - 1));
      chk("dout", {8'd0, dout}, {8'd0, pix(last_y - 1, last_x - 1)});
    end
    if (exp_win) begin
      chk("d02", {8'd0, D02OUT}, {8'd0, pix(y - 2, x - 2)});
      chk("d01", {8'd0, D01OUT}, {8'd0, pix(y - 2, x - 1)});
      chk("d00", {8'd0, D00OUT}, {8'd0, pix(y - 2, x)});
      chk("d12", {8'd0, D12OUT}, {8'd0, pix(y - 1, x - 2)});
      chk("d11", {8'd0, D11OUT}, {8'd0, pix(y - 1, x - 1)});
      chk("d10", {8'd0, D10OUT}, {8'd0, pix(y - 1, x)});
      chk("d22", {8'd0, D22OUT}, {8'd0, pix(y, x - 2)});
      chk("d21", {8'd0, D21OUT}, {8'd0, pix(y, x - 1)});
      chk("d20", {8'd0, D20OUT}, {8'd0, pix(y, x)});
    end
    last_win = exp_win;
    last_x   = x;
    last_y   = y;
  endtask

  // First n pixels of a clean frame in raster order, optional idle cycle after each.
  task automatic pixels(input int n, input bit stall);
    for (int i = 0; i < n; i++) begin
      int y = i / 4;
      int x = i % 4;
      step(1'b1, (i == 0), (x == 0), y, x, (y >= 2 && x >= 2));
      if (stall) begin
        step(1'b0, 1'b0, 1'b0, y, x, 1'b0);
        chk("stall_hold_d20", {8'd0, D20OUT}, {8'd0, pix(y, x)});
      end
    end
  endtask

  task automatic flush();
    step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_taps"}, {8'd0, D00OUT | D01OUT | D02OUT | D10OUT | D11OUT | D12OUT |
                         D20OUT | D21OUT | D22OUT}, 32'd0);
    chk({tag, "_win"}, {31'd0, WIN_VALID}, 32'd0);
    chk({tag, "_avg"}, {31'd0, AVG_VALID}, 32'd0);
    chk({tag, "_avg_x"}, 32'(AVG_X), 32'd0);
    chk({tag, "_avg_y"}, 32'(AVG_Y), 32'd0);
    chk({tag, "_err"}, {31'd0, ERR}, 32'd0);
  endtask

  initial begin
    RESET = 1'b1; DIN = '0; DIN_VALID = 1'b0; DIN_SOF = 1'b0; DIN_SOL = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk_all_zero("reset");
    RESET = 1'b0;

    // Clean frame, no stalls: 4 windows.
    avg_pulses = 0;
    pixels(16, 1'b0);
    flush();
    chk("pulses_clean", 32'(avg_pulses), 32'd4);

    // Same frame with an idle cycle after every pixel.
    avg_pulses = 0;
    pixels(16, 1'b1);
    flush();
    chk("pulses_stall", 32'(avg_pulses), 32'd4);

    // SOF arrives where pixel (2,1) would be; only the new frame produces windows.
    avg_pulses = 0;
    pixels(9, 1'b0);
    pixels(16, 1'b0);
    flush();
    chk("pulses_midsof", 32'(avg_pulses), 32'd4);

    // Reset during row 3, with a valid pixel presented in the same cycle.
    pixels(14, 1'b0);
    RESET = 1'b1; DIN_VALID = 1'b1; DIN_SOF = 1'b0; DIN_SOL = 1'b0; DIN = pix(3, 2);
    @(negedge CLK);
    chk_all_zero("midreset");
    RESET = 1'b0;
    last_win = 1'b0;
    step(1'b1, 1'b0, 1'b1, 0, 0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 0, 1, 1'b0);
    chk("idle_ignores", {8'd0, D20OUT}, 32'd0);
    avg_pulses = 0;
    pixels(16, 1'b0);
    flush();
    chk("pulses_after_reset", 32'(avg_pulses), 32'd4);

    // Two frames back-to-back.
    avg_pulses = 0;
    pixels(16, 1'b0);
    pixels(16, 1'b0);
    flush();
    chk("pulses_b2b", 32'(avg_pulses), 32'd8);

`ifdef AVG_CTRL_ERR_EN
    // Short second line flags ERR at the next SOL; no windows until a new SOF.
    for (int x = 0; x < 4; x++) step(1'b1, (x == 0), (x == 0), 0, x, 1'b0);
    for (int x = 0; x < 3; x++) step(1'b1, 1'b0, (x == 0), 1, x, 1'b0);
    err_exp = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, (i % 4 == 0), 2 + i / 4, i % 4, 1'b0);
    avg_pulses = 0;
    pixels(16, 1'b0);
    flush();
    chk("pulses_after_err", 32'(avg_pulses), 32'd4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
